// File: rtl/three_bit_pkg.sv
// Shared width constant for consumers that rebuild the bit-port operands into vectors.
package three_bit_pkg;

    localparam int WIDTH = 3;

endpackage

// File: rtl/three_bit_full_adder.sv
// One-bit full adder cell for the ripple chain.
// Latency: purely combinational, no state.
// Backpressure: none; evaluates every cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/three_bit.sv
// Registered 3-bit ripple-carry adder with carry-out, valid strobe and sticky overflow.
// Latency: 1 cycle from in_valid edge to out_valid/sum/cout.
// Backpressure: none; accepts one addition every cycle, results hold while in_valid is low.
module three_bit
    import three_bit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic sum0,
    output logic sum1,
    output logic sum2,
    output logic cout,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic in_valid,
    output logic out_valid,
    output logic ovf,
    input  logic ovf_clr
);

    logic [WIDTH-1:0] a_vec;
    logic [WIDTH-1:0] b_vec;
    logic [WIDTH-1:0] s_vec;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;
    logic             ovf_q;

    assign a_vec    = {a2, a1, a0};
    assign b_vec    = {b2, b1, b0};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (a_vec[i]),
            .b    (b_vec[i]),
            .cin  (carry[i]),
            .s    (s_vec[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= s_vec;
                cout_q <= carry[WIDTH];
            end
            // An accepted carry beats a simultaneous clear.
            if (in_valid && carry[WIDTH]) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign sum0      = sum_q[0];
    assign sum1      = sum_q[1];
    assign sum2      = sum_q[2];
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_three_bit.sv
// Bench for three_bit: directed cases, exhaustive operand sweep and random traffic against an arithmetic model.
module tb_three_bit;

    logic clk = 1'b0;
    logic rst_n;
    logic sum0, sum1, sum2, cout;
    logic a0, a1, a2, b0, b1, b2;
    logic in_valid, out_valid, ovf, ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    int exp_sum  = 0;
    int exp_cout = 0;
    int exp_vld  = 0;
    int exp_ovf  = 0;

    three_bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sum0      (sum0),
        .sum1      (sum1),
        .sum2      (sum2),
        .cout      (cout),
        .a0        (a0),
        .a1        (a1),
        .a2        (a2),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sum"},  int'({sum2, sum1, sum0}), exp_sum);
        chk({tag, ".cout"}, int'(cout), exp_cout);
        chk({tag, ".vld"},  int'(out_valid), exp_vld);
        chk({tag, ".ovf"},  int'(ovf), exp_ovf);
    endtask

    task automatic drive(input int a, input int b, input bit v, input bit clr);
        a0 = a[0]; a1 = a[1]; a2 = a[2];
        b0 = b[0]; b1 = b[1]; b2 = b[2];
        in_valid = v;
        ovf_clr  = clr;
    endtask

    // Apply operands, take one edge, advance the model, then compare just after the edge.
    task automatic step(input string tag, input int a, input int b, input bit v, input bit clr);
        int r;
        drive(a, b, v, clr);
        @(posedge clk);
        r = a + b;
        exp_vld = v ? 1 : 0;
        if (v) begin
            exp_sum  = r % 8;
            exp_cout = r / 8;
        end
        if (v && r > 7) exp_ovf = 1;
        else if (clr)   exp_ovf = 0;
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_sum = 0; exp_cout = 0; exp_vld = 0; exp_ovf = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, 1'b0);
        model_reset();
        #1;
        check_all("reset_now");
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_held");

        drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
        rst_n = 1'b1;
        step("idle0", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0);
        step("idle1", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0);

        step("6p1", 6, 1, 1'b1, 1'b0);
        chk("6p1.const_sum", int'({sum2, sum1, sum0}), 7);
        step("2p3", 2, 3, 1'b1, 1'b0);
        chk("2p3.const_sum", int'({sum2, sum1, sum0}), 5);
        step("hold", 7, 6, 1'b0, 1'b0);
        chk("hold.const_sum", int'({sum2, sum1, sum0}), 5);
        step("5p4", 5, 4, 1'b1, 1'b0);
        chk("5p4.const_ovf", int'(ovf), 1);
        step("6p4", 6, 4, 1'b1, 1'b0);
        chk("6p4.const_sum", int'({sum2, sum1, sum0}), 2);
        step("clr", 3, 3, 1'b0, 1'b1);
        chk("clr.const_ovf", int'(ovf), 0);
        step("clr_7p7", 7, 7, 1'b1, 1'b1);
        chk("clr_7p7.const_ovf", int'(ovf), 1);
        step("clr_nocarry", 1, 1, 1'b1, 1'b1);

        for (int i = 0; i < 64; i++) begin
            step("sweep", i / 8, i % 8, 1'b1, 1'b0);
            chk("sweep.total", int'({cout, sum2, sum1, sum0}), (i / 8) + (i % 8));
        end

        for (int i = 0; i < 300; i++) begin
            step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-cycle drops the pending result at once.
        step("pre_rst", 7, 5, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst", 3, 4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/three_bit.md
# three_bit

Registered 3-bit unsigned ripple-carry adder with carry-out, used as a small arithmetic leaf in the datapath. Operands arrive as individual bit ports. Results are registered with one cycle of latency, a valid strobe and a sticky overflow flag. A combinational full-adder cell is the only sub-block.

## Interface
Parameters:
- none; the operand width is fixed at 3 bits.

Ports (clock and reset first, then data ports in this positional order):
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sum0  output  1  registered sum bit 0 (LSB).
- sum1  output  1  registered sum bit 1.
- sum2  output  1  registered sum bit 2 (MSB).
- cout  output  1  registered carry-out of bit 2.
- a0, a1, a2  input  1 each  operand A bits, LSB first.
- b0, b1, b2  input  1 each  operand B bits, LSB first.
- in_valid  input  1  operands are valid this cycle.
- out_valid  output  1  sum/cout registers hold a result accepted on the previous edge.
- ovf  output  1  sticky flag, set by any accepted addition with carry-out.
- ovf_clr  input  1  synchronous clear of ovf.

## Operation
- A = {a2,a1,a0} and B = {b2,b1,b0} are unsigned values 0..7.
- The adder computes the 4-bit result {cout,sum2,sum1,sum0} = A + B, range 0..14. No carry-in; bit 0 carry-in is tied to 0.
- The result is a ripple chain of three full adders. Stage i: s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | c_i&(a_i^b_i). cout = c_3.
- On a rising edge with in_valid=1:
  - The sum bits and cout are loaded with the new result.
  - out_valid is loaded with 1.
  - If the new cout is 1, ovf is set.
- On a rising edge with in_valid=0:
  - The sum bits and cout hold their previous values.
  - out_valid is loaded with 0.
- ovf_clr=1 on an edge clears ovf. If a carry is accepted on the same edge, set wins and ovf=1.
- cout=1 means the result does not fit in 3 bits. Downstream logic treats it as overflow. sum then holds the result modulo 8.

## Timing
- Latency: 1 cycle. Operands sampled at edge N appear on sum*/cout/out_valid after edge N.
- Throughput: one addition per cycle. Back-to-back in_valid pulses produce back-to-back out_valid.
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - sum0..2, cout, out_valid and ovf all go to 0.
  - Outputs stay 0 while rst_n is low.
  - After release, the first edge with in_valid=1 produces the first result.
- Reset in the middle of operation discards the pending result. out_valid is 0 after reset.
- No combinational path from inputs to outputs. All outputs are driven directly by flops.

## Structure
- No shared package is needed. Optionally, a package may hold the localparam WIDTH=3, for consumers that reassemble the bit ports into vectors.
- Sub-module full_adder: inputs a, b, cin; outputs s, cout; purely combinational. Instantiate it three times in the ripple chain.
- The top level contains the three full_adder instances, the output register bank, out_valid, and the sticky ovf logic.

## Test plan
- Reset: assert rst_n=0 with random inputs -> sum=0, cout=0, out_valid=0 and ovf=0 immediately. All stay 0 after release until in_valid is asserted.
- No overflow: A=6, B=1, in_valid=1 -> next cycle sum=7, cout=0, out_valid=1, ovf=0. A=2, B=3 -> sum=5, cout=0.
- Overflow: A=5, B=4 -> sum=1, cout=1, ovf=1. A=6, B=4 -> sum=2, cout=1, ovf remains 1.
- Hold: drop in_valid after A=2, B=3 while changing the operands -> sum stays 5, out_valid=0.
- Sticky flag: after an overflow, pulse ovf_clr with in_valid=0 -> ovf=0. Pulse ovf_clr together with A=7, B=7 -> sum=6, cout=1, ovf=1 (set wins).
- Exhaustive: all 64 (A,B) pairs streamed back-to-back -> each {cout,sum} equals A+B exactly one cycle later.
